uart_tx: RTL and testbench

//   Serial UART transmitter; the sending end of the link that uart_rx receives.

---
 rtl/uart_tx.sv | 204 ++++++++++++++++++++
 tb/tb_uart_tx.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx.sv
// uart_tx: byte-wide UART transmitter (start bit, 8 data bits MSB first, stop bit).
// Bytes arrive over a valid/ready handshake and are buffered ahead of the shifter.
// Define UART_TX_FIFO_EN to buffer up to FIFO_DEPTH bytes in a circular FIFO;
// without it a single holding register is used and FIFO_DEPTH only sets the
// width of fifo_level.
module uart_tx #(
  parameter int CLKS_PER_BIT = 1,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [7:0]                    data_in,
  output logic                          tx,
  output logic                          busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

  localparam int LW = $clog2(FIFO_DEPTH) + 1;
  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] BAUD_MAX = CW'(CLKS_PER_BIT - 1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  // Buffer interface shared by both build variants
  logic          push;
  logic          pop;
  logic          buf_full;
  logic          buf_empty;
  logic [7:0]    buf_data;
  logic [LW-1:0] buf_level;

  assign push = in_valid && !buf_full;

`ifdef UART_TX_FIFO_EN
  localparam int AW = LW - 1;

  // Pointers carry one wrap bit above the index so full and empty differ
  logic [7:0]    mem_q [FIFO_DEPTH];
  logic [LW-1:0] wr_ptr_q, wr_ptr_d;
  logic [LW-1:0] rd_ptr_q, rd_ptr_d;

  assign buf_full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                     (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign buf_empty = (wr_ptr_q == rd_ptr_q);
  assign buf_level = wr_ptr_q - rd_ptr_q;
  assign buf_data  = mem_q[rd_ptr_q[AW-1:0]];

  // Advance pointers on push/pop; both may move in the same cycle
  always_comb begin
    wr_ptr_d = wr_ptr_q + LW'(push);
    rd_ptr_d = rd_ptr_q + LW'(pop);
  end

  // Pointer registers; reset discards all buffered bytes
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Byte storage, written at the write index on push
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q[AW-1:0]] <= data_in;
    end
  end
`else
  // Single holding register: one byte can wait while a frame is in flight
  logic [7:0] hold_q, hold_d;
  logic       hold_valid_q, hold_valid_d;

  assign buf_full  = hold_valid_q;
  assign buf_empty = !hold_valid_q;
  assign buf_level = {{(LW-1){1'b0}}, hold_valid_q};
  assign buf_data  = hold_q;

  // Push only when empty and pop only when full, so they never coincide
  always_comb begin
    hold_d       = hold_q;
    hold_valid_d = hold_valid_q;
    if (push) begin
      hold_d       = data_in;
      hold_valid_d = 1'b1;
    end else if (pop) begin
      hold_valid_d = 1'b0;
    end
  end

  // Holding register state; the byte itself is not reset
  always_ff @(posedge clk) begin
    if (rst) begin
      hold_valid_q <= 1'b0;
    end else begin
      hold_valid_q <= hold_valid_d;
    end
    hold_q <= hold_d;
  end
`endif

  // Framing state
  state_t        state_q, state_d;
  logic [CW-1:0] baud_q, baud_d;
  logic [2:0]    bit_cnt_q, bit_cnt_d;
  logic [7:0]    shift_q, shift_d;
  logic          tx_q, tx_d;
  logic          baud_wrap;

  assign baud_wrap = (baud_q == BAUD_MAX);

  // Next-state logic; tx is derived from the next state so the line is registered
  always_comb begin
    state_d   = state_q;
    baud_d    = baud_q;
    bit_cnt_d = bit_cnt_q;
    shift_d   = shift_q;
    pop       = 1'b0;
    case (state_q)
      IDLE: begin
        if (!buf_empty) begin
          pop     = 1'b1;
          shift_d = buf_data;
          baud_d  = '0;
          state_d = START;
        end
      end
      START: begin
        if (baud_wrap) begin
          baud_d    = '0;
          bit_cnt_d = 3'd0;
          state_d   = DATA;
        end else begin
          baud_d = baud_q + CW'(1);
        end
      end
      DATA: begin
        if (baud_wrap) begin
          baud_d  = '0;
          shift_d = {shift_q[6:0], 1'b0};
          if (bit_cnt_q == 3'd7) begin
            bit_cnt_d = 3'd0;
            state_d   = STOP;
          end else begin
            bit_cnt_d = bit_cnt_q + 3'd1;
          end
        end else begin
          baud_d = baud_q + CW'(1);
        end
      end
      STOP: begin
        if (baud_wrap) begin
          baud_d = '0;
          if (!buf_empty) begin
            pop     = 1'b1;
            shift_d = buf_data;
            state_d = START;
          end else begin
            state_d = IDLE;
          end
        end else begin
          baud_d = baud_q + CW'(1);
        end
      end
      default: state_d = IDLE;
    endcase

    case (state_d)
      START:   tx_d = 1'b0;
      DATA:    tx_d = shift_d[7];
      default: tx_d = 1'b1;
    endcase
  end

  // Control registers; reset aborts any frame and forces the line idle
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      baud_q    <= '0;
      bit_cnt_q <= 3'd0;
      tx_q      <= 1'b1;
    end else begin
      state_q   <= state_d;
      baud_q    <= baud_d;
      bit_cnt_q <= bit_cnt_d;
      tx_q      <= tx_d;
    end
  end

  // Shift register holds data only, so it carries no reset
  always_ff @(posedge clk) begin
    shift_q <= shift_d;
  end

  assign tx         = tx_q;
  assign in_ready   = !buf_full;
  assign fifo_level = buf_level;
  assign busy       = (state_q != IDLE) || (buf_level != '0);

endmodule

// File: tb/tb_uart_tx.sv
// Directed bench for uart_tx: one instance at one clock per bit, one at four.
module tb_uart_tx;

`ifdef UART_TX_FIFO_EN
  localparam int DEPTH_EFF = 4;
`else
  localparam int DEPTH_EFF = 1;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic       v1, r1, tx1, b1;
  logic [7:0] d1;
  logic [2:0] l1;
  logic       v4, r4, tx4, b4;
  logic [7:0] d4;
  logic [2:0] l4;

  int errs   = 0;
  int checks = 0;

  always #5 clk = ~clk;

  uart_tx #(.CLKS_PER_BIT(1), .FIFO_DEPTH(4)) dut1 (
    .clk(clk), .rst(rst), .in_valid(v1), .in_ready(r1), .data_in(d1),
    .tx(tx1), .busy(b1), .fifo_level(l1)
  );

  uart_tx #(.CLKS_PER_BIT(4), .FIFO_DEPTH(4)) dut4 (
    .clk(clk), .rst(rst), .in_valid(v4), .in_ready(r4), .data_in(d4),
    .tx(tx4), .busy(b4), .fifo_level(l4)
  );

  typedef struct {
    string      name;
    logic [7:0] din;
    logic [9:0] frame;   // bit 9 is sent first
  } vec_t;

  vec_t vecs[5];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Called at a negedge; returns at the negedge after the accepting edge
  task automatic push_byte(input logic [7:0] b, output int edges);
    logic acc;
    acc   = 1'b0;
    edges = 0;
    v1    = 1'b1;
    d1    = b;
    for (int n = 0; n < 100 && !acc; n++) begin
      acc = r1;
      @(posedge clk);
      edges++;
      @(negedge clk);
    end
    v1 = 1'b0;
    if (!acc) begin
      checks++;
      errs++;
      $display("FAIL push_timeout: got in_ready=0 expected 1 within 100 cycles");
    end
  endtask

  // Samples the chosen tx line 1 time unit after each of the next n edges
  task automatic collect(input int which, input int n, output logic [63:0] bits);
    bits = '0;
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      bits = {bits[62:0], (which == 4) ? tx4 : tx1};
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [63:0] bits;
    logic [63:0] exp40;
    int          e;
    int          e2;
    logic [7:0]  stream_bytes[6];
    logic        samp[80];
    int          maxl;
    int          bad;
    logic [7:0]  got[$];
    int          stop_bad;

    vecs[0] = '{"A5",   8'hA5, 10'b0101001011};
    vecs[1] = '{"3C",   8'h3C, 10'b0001111001};
    vecs[2] = '{"00",   8'h00, 10'b0000000001};
    vecs[3] = '{"FF",   8'hFF, 10'b0111111111};
    vecs[4] = '{"01",   8'h01, 10'b0000000011};

    rst = 1'b1; v1 = 1'b0; d1 = 8'h00; v4 = 1'b0; d4 = 8'h00;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_tx",     64'(tx1), 64'd1);
    chk("rst_ready",  64'(r1),  64'd1);
    chk("rst_busy",   64'(b1),  64'd0);
    chk("rst_level",  64'(l1),  64'd0);
    chk("rst_tx4",    64'(tx4), 64'd1);
    chk("rst_busy4",  64'(b4),  64'd0);
    @(negedge clk);
    rst = 1'b0;

    // data_in without in_valid must not start anything
    d1 = 8'h55;
    repeat (5) @(negedge clk);
    chk("ignore_tx",   64'(tx1), 64'd1);
    chk("ignore_busy", 64'(b1),  64'd0);

    // Single frames from idle
    for (int i = 0; i < 5; i++) begin
      push_byte(vecs[i].din, e);
      collect(1, 10, bits);
      chk({"frame_", vecs[i].name}, bits[9:0], 64'(vecs[i].frame));
      chk({"busy_stop_", vecs[i].name}, 64'(b1), 64'd1);
      collect(1, 1, bits);
      chk({"idle_tx_", vecs[i].name}, bits[0], 64'd1);
      chk({"idle_busy_", vecs[i].name}, 64'(b1), 64'd0);
      @(negedge clk);
    end

    // Back-to-back frames: 0x00 then 0xFF with no idle gap
    push_byte(8'h00, e);
    fork
      push_byte(8'hFF, e2);
      collect(1, 20, bits);
    join
    chk("b2b_bits", bits[19:0], 64'(20'b0000000001_0111111111));
    collect(1, 1, bits);
    chk("b2b_idle_tx",   bits[0], 64'd1);
    chk("b2b_idle_busy", 64'(b1), 64'd0);
    @(negedge clk);

    // Streaming six bytes with in_valid held high
    for (int i = 0; i < 6; i++) stream_bytes[i] = 8'(i + 1);
    maxl = 0;
    bad  = 0;
    fork
      begin : pusher
        int idx;
        logic acc;
        idx = 0;
        v1  = 1'b1;
        d1  = stream_bytes[0];
        for (int n = 0; n < 100 && idx < 6; n++) begin
          acc = r1;
          @(posedge clk);
          if (acc) idx++;
          @(negedge clk);
          if (idx < 6) d1 = stream_bytes[idx];
        end
        v1 = 1'b0;
      end
      begin : monitor
        for (int c = 0; c < 80; c++) begin
          @(posedge clk);
          #1;
          samp[c] = tx1;
          if (int'(l1) > maxl) maxl = int'(l1);
          if (int'(l1) == DEPTH_EFF && r1) bad++;
          if (int'(l1) <  DEPTH_EFF && !r1) bad++;
        end
      end
    join
    chk("stream_max_level", 64'(maxl), 64'(DEPTH_EFF));
    chk("stream_ready_vs_level", 64'(bad), 64'd0);
    stop_bad = 0;
    for (int p = 0; p < 80; ) begin
      if (samp[p] == 1'b0 && p + 9 < 80) begin
        logic [7:0] by;
        for (int k = 1; k <= 8; k++) by = {by[6:0], samp[p+k]};
        if (samp[p+9] != 1'b1) stop_bad++;
        got.push_back(by);
        p += 10;
      end else begin
        p++;
      end
    end
    chk("stream_count", 64'(got.size()), 64'd6);
    chk("stream_stop_bits", 64'(stop_bad), 64'd0);
    for (int i = 0; i < 6; i++) begin
      chk($sformatf("stream_byte%0d", i), (i < got.size()) ? 64'(got[i]) : 64'hFFFF,
          64'(stream_bytes[i]));
    end
    @(negedge clk);

    // Reset during data bit D3 with a second byte waiting
    push_byte(8'hF7, e);
    push_byte(8'hC3, e2);
    repeat (6 - e2) @(negedge clk);
    chk("abort_phase_d3", 64'(tx1), 64'd0);
    chk("abort_busy_pre", 64'(b1),  64'd1);
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("abort_tx",    64'(tx1), 64'd1);
    chk("abort_busy",  64'(b1),  64'd0);
    chk("abort_level", 64'(l1),  64'd0);
    chk("abort_ready", 64'(r1),  64'd1);
    @(negedge clk);
    rst = 1'b0;
    collect(1, 15, bits);
    chk("abort_no_start", bits[14:0], 64'h7FFF);
    @(negedge clk);

    // Four clocks per bit: 0x80
    v4 = 1'b1;
    d4 = 8'h80;
    @(posedge clk);
    @(negedge clk);
    v4 = 1'b0;
    exp40 = {24'd0, 4'b0000, 4'b1111, 28'd0, 4'b1111} ;
    exp40 = {24'd0, exp40[39:0]};
    collect(4, 40, bits);
    chk("cpb4_frame", bits[39:0], exp40);
    chk("cpb4_busy_stop", 64'(b4), 64'd1);
    collect(4, 1, bits);
    chk("cpb4_idle_tx",   bits[0], 64'd1);
    chk("cpb4_idle_busy", 64'(b4), 64'd0);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
